// File: rtl/fifo_pkg.sv
// Shared sizing helpers and defaults for the valid/ready FIFO and its bench.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Pointer width for a given depth: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_w(DEF_DEPTH)-1:0] def_ptr_t;

endpackage

// File: rtl/valid_ready.sv
// Valid/ready handshake bundle; Slave receives words, Master presents them.
interface valid_ready #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport Slave  (input  valid, input  data, output ready);
    modport Master (output valid, output data, input  ready);
endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [addr_w(DEPTH)-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [addr_w(DEPTH)-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vr_fifo.sv
// Show-ahead valid/ready FIFO absorbing sink back-pressure; a pushed word is
// visible on out_bus after the pushing edge, with no in->out combinational path.
module vr_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int ALMOST_FULL_LVL = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    valid_ready.Slave              in_bus,
    valid_ready.Master             out_bus,
    output logic [addr_w(DEPTH):0] level,
    output logic                   almost_full
);

    localparam int ADDR = addr_w(DEPTH);
    typedef logic [ADDR:0] ptr_t;
    localparam ptr_t AF_LVL  = ptr_t'(ALMOST_FULL_LVL);
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vr_fifo: DEPTH must be a power of two and at least 2");
    end

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    logic                  empty, full, push, pop;
    logic [DATA_WIDTH-1:0] rd_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]) &&
                   (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]);

    // Ready is held low during reset so nothing is accepted into a clearing FIFO.
    assign push = in_bus.valid && !full && !reset;
    assign pop  = out_bus.ready && !empty;

    assign in_bus.ready  = !full && !reset;
    assign out_bus.valid = !empty;
    assign out_bus.data  = empty ? '0 : rd_data;

    assign level       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (level >= AF_LVL);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[ADDR-1:0]),
        .wdata_i (in_bus.data),
        .raddr_i (rd_ptr_q[ADDR-1:0]),
        .rdata_o (rd_data)
    );

    a_no_overrun: assert property (@(posedge clk) disable iff (reset)
        level <= DEPTH_P);

endmodule

// File: tb/tb_vr_fifo.sv
// Randomised and directed checks of vr_fifo against a queue-based reference model.
module tb_vr_fifo;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    typedef logic [ptr_w(DEPTH)-1:0] ptr_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [addr_w(DEPTH):0] level;
    logic           almost_full;
    int             total = 0;
    int             bad   = 0;
    logic [DW-1:0]  mq[$];
    logic [DW-1:0]  rxq[$];

    valid_ready #(.DATA_WIDTH(DW)) in_if ();
    valid_ready #(.DATA_WIDTH(DW)) out_if ();

    vr_fifo #(
        .DATA_WIDTH      (DW),
        .DEPTH           (DEPTH),
        .ALMOST_FULL_LVL (AFL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_bus      (in_if),
        .out_bus     (out_if),
        .level       (level),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    // Called just after a falling edge; advances one clock and updates the model.
    task automatic tick();
        bit push, pop;
        push = in_if.valid && (mq.size() < DEPTH);
        pop  = out_if.ready && (mq.size() > 0);
        if (out_if.valid && out_if.ready) rxq.push_back(out_if.data);
        @(posedge clk);
        if (pop)  mq.delete(0);
        if (push) mq.push_back(in_if.data);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b0;
        @(negedge clk);
        total++; if (in_if.ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", in_if.ready); end
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_if.valid); end
        total++; if (level !== ptr_t'(0)) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af: got %b want 0", almost_full); end
        total++; if (out_if.data !== '0) begin bad++; $display("FAIL rst_data: got %h want 00", out_if.data); end
        reset = 1'b0;
        tick();
        tick();
        total++; if (in_if.ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", in_if.ready); end
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", out_if.valid); end
        total++; if (level !== ptr_t'(0)) begin bad++; $display("FAIL idle_level: got %0d want 0", level); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_if.valid = 1'b1;
            in_if.data = words[i];
            tick();
            total++; if (level !== ptr_t'(mq.size())) begin bad++; $display("FAIL fill_level: got %0d want %0d", level, mq.size()); end
            total++; if (almost_full !== (mq.size() >= AFL)) begin bad++; $display("FAIL fill_af: got %b want %b", almost_full, mq.size() >= AFL); end
        end
        total++; if (in_if.ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", in_if.ready); end
        in_if.data = 8'h55;
        tick();
        in_if.valid = 1'b0;
        total++; if (level !== ptr_t'(4)) begin bad++; $display("FAIL full_level: got %0d want 4", level); end
        total++; if (out_if.data !== 8'h11) begin bad++; $display("FAIL full_head: got %h want 11", out_if.data); end
    endtask

    task automatic test_drain();
        logic [DW-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_if.valid !== 1'b1 || out_if.data !== words[i]) begin bad++; $display("FAIL drain_word%0d: got %b/%h want 1/%h", i, out_if.valid, out_if.data, words[i]); end
            tick();
            total++; if (in_if.ready !== 1'b1) begin bad++; $display("FAIL drain_ready%0d: got %b want 1", i, in_if.ready); end
        end
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", out_if.valid); end
        total++; if (level !== ptr_t'(0)) begin bad++; $display("FAIL drain_level: got %0d want 0", level); end
        out_if.ready = 1'b0;
    endtask

    task automatic test_stream();
        rxq.delete();
        out_if.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_if.valid = 1'b1;
            in_if.data = DW'(i);
            if (i == 0) begin
                #1;
                total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL stream_bypass: got %b want 0", out_if.valid); end
            end
            tick();
            total++; if (level !== ptr_t'(1) || out_if.data !== DW'(i)) begin bad++; $display("FAIL stream_c%0d: got lvl %0d data %h want lvl 1 data %h", i, level, out_if.data, DW'(i)); end
        end
        in_if.valid = 1'b0;
        tick();
        total++; if (rxq.size() != 20) begin bad++; $display("FAIL stream_count: got %0d want 20", rxq.size()); end
        for (int i = 0; i < rxq.size() && i < 20; i++) begin
            total++; if (rxq[i] !== DW'(i)) begin bad++; $display("FAIL stream_order%0d: got %h want %h", i, rxq[i], DW'(i)); end
        end
        out_if.ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] sent[$];
        int cyc = 0;
        bit acc;
        rxq.delete();
        in_if.valid = 1'b0;
        while ((sent.size() < 50 || rxq.size() < 50) && cyc < 2000) begin
            if (!in_if.valid && sent.size() < 50 && $urandom_range(0, 3) != 0) begin
                in_if.valid = 1'b1;
                in_if.data = DW'($urandom);
            end
            out_if.ready = (cyc % 3 == 0);
            total++; if (level !== ptr_t'(mq.size()) || in_if.ready !== (mq.size() < DEPTH) ||
                         almost_full !== (mq.size() >= AFL)) begin
                bad++; $display("FAIL wrap_flags c%0d: got lvl %0d rdy %b af %b want lvl %0d", cyc, level, in_if.ready, almost_full, mq.size());
            end
            total++; if (out_if.valid !== (mq.size() > 0) || out_if.data !== (mq.size() > 0 ? mq[0] : DW'(0))) begin
                bad++; $display("FAIL wrap_head c%0d: got %b/%h", cyc, out_if.valid, out_if.data);
            end
            acc = in_if.valid && (mq.size() < DEPTH);
            tick();
            if (acc) begin
                sent.push_back(in_if.data);
                in_if.valid = 1'b0;
            end
            cyc++;
        end
        total++; if (cyc >= 2000) begin bad++; $display("FAIL wrap_timeout: got %0d cycles want < 2000", cyc); end
        total++; if (rxq.size() != 50) begin bad++; $display("FAIL wrap_count: got %0d want 50", rxq.size()); end
        for (int i = 0; i < rxq.size() && i < sent.size(); i++) begin
            total++; if (rxq[i] !== sent[i]) begin bad++; $display("FAIL wrap_order%0d: got %h want %h", i, rxq[i], sent[i]); end
        end
        out_if.ready = 1'b0;
        in_if.valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        rxq.delete();
        out_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_if.valid = 1'b1;
            in_if.data = DW'(8'hC0 + i);
            tick();
        end
        in_if.valid = 1'b0;
        total++; if (level !== ptr_t'(3)) begin bad++; $display("FAIL mid_pre_level: got %0d want 3", level); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_if.valid); end
        total++; if (level !== ptr_t'(0)) begin bad++; $display("FAIL mid_level: got %0d want 0", level); end
        total++; if (in_if.ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", in_if.ready); end
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        in_if.valid = 1'b1;
        in_if.data = 8'hAA;
        tick();
        in_if.valid = 1'b0;
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 8'hAA) begin bad++; $display("FAIL mid_first: got %b/%h want 1/aa", out_if.valid, out_if.data); end
        out_if.ready = 1'b1;
        tick();
        total++; if (rxq.size() != 1 || rxq[0] !== 8'hAA || level !== ptr_t'(0)) begin bad++; $display("FAIL mid_pop: got n=%0d lvl %0d want n=1 lvl 0", rxq.size(), level); end
        out_if.ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
